// File: rtl/fractal_sync_arbiter_hs.sv
// Multi-output arbiter: pops input FIFOs into registered, back-pressurable output slots.
// Round-robin or fixed-priority scheduling, with per-input aging to bound wait time.
module fractal_sync_arbiter_hs #(
  parameter int unsigned IN_PORTS  = 4,
  parameter int unsigned OUT_PORTS = 2,
  parameter type         arbiter_t = logic,
  parameter int unsigned ARB_MODE  = 0,
  parameter int unsigned MAX_WAIT  = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  output logic     [IN_PORTS-1:0]        pop_o,
  input  logic     [IN_PORTS-1:0]        empty_i,
  input  arbiter_t [IN_PORTS-1:0]        element_i,
  output logic     [OUT_PORTS-1:0]       valid_o,
  input  logic     [OUT_PORTS-1:0]       ready_i,
  output arbiter_t [OUT_PORTS-1:0]       element_o
);

  localparam int unsigned PtrW  = (IN_PORTS > 1) ? $clog2(IN_PORTS) : 1;
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  typedef logic [PtrW-1:0]  ptr_t;
  typedef logic [WaitW-1:0] wait_t;

  localparam wait_t MaxWait = wait_t'(MAX_WAIT);
  localparam ptr_t  LastIdx = ptr_t'(IN_PORTS - 1);

  logic     [OUT_PORTS-1:0]           valid_q, valid_d;
  arbiter_t [OUT_PORTS-1:0]           data_q, data_d;
  ptr_t                               rr_q, rr_d;
  wait_t    [IN_PORTS-1:0]            wait_q, wait_d;

  logic     [IN_PORTS-1:0]            req, starved, avail, grant;
  logic     [OUT_PORTS-1:0]           slot_free, slot_hit;
  logic     [OUT_PORTS-1:0][PtrW-1:0] slot_sel;
  logic                               found, rr_hit;
  ptr_t                               sel, cand, rr_last, scan_start;
  int unsigned                        pos;

  assign req        = ~empty_i;
  assign slot_free  = ~valid_q | ready_i;
  assign scan_start = (ARB_MODE == 0) ? rr_q : '0;

  always_comb begin
    for (int j = 0; j < int'(IN_PORTS); j++) begin
      starved[j] = req[j] && (wait_q[j] == MaxWait);
    end
  end

  // Each free slot, in ascending order, takes the next candidate: starved inputs
  // first, then the scan order of the selected mode. Granted inputs leave the pool.
  always_comb begin
    avail    = req;
    grant    = '0;
    slot_hit = '0;
    slot_sel = '0;
    rr_hit   = 1'b0;
    rr_last  = '0;
    found    = 1'b0;
    sel      = '0;
    cand     = '0;
    pos      = 0;
    for (int k = 0; k < int'(OUT_PORTS); k++) begin
      if (slot_free[k]) begin
        found = 1'b0;
        sel   = '0;
        for (int j = 0; j < int'(IN_PORTS); j++) begin
          if (!found && avail[j] && starved[j]) begin
            found = 1'b1;
            sel   = ptr_t'(j);
          end
        end
        if (!found) begin
          for (int off = 0; off < int'(IN_PORTS); off++) begin
            pos = int'(scan_start) + off;
            if (pos >= IN_PORTS) begin
              pos = pos - IN_PORTS;
            end
            cand = ptr_t'(pos);
            if (!found && avail[cand]) begin
              found   = 1'b1;
              sel     = cand;
              rr_hit  = 1'b1;
              rr_last = cand;
            end
          end
        end
        if (found) begin
          avail[sel]  = 1'b0;
          grant[sel]  = 1'b1;
          slot_hit[k] = 1'b1;
          slot_sel[k] = sel;
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < int'(OUT_PORTS); k++) begin
      if (slot_free[k]) begin
        if (slot_hit[k]) begin
          valid_d[k] = 1'b1;
          data_d[k]  = element_i[ptr_t'(slot_sel[k])];
        end else begin
          valid_d[k] = 1'b0;
          data_d[k]  = '0;
        end
      end
    end
  end

  // Only round-robin-phase grants move the pointer; starvation grants leave it alone.
  always_comb begin
    rr_d = rr_q;
    if ((ARB_MODE == 0) && rr_hit) begin
      rr_d = (rr_last == LastIdx) ? '0 : rr_last + ptr_t'(1);
    end
  end

  always_comb begin
    wait_d = wait_q;
    for (int j = 0; j < int'(IN_PORTS); j++) begin
      if (grant[j] || empty_i[j]) begin
        wait_d[j] = '0;
      end else if (wait_q[j] != MaxWait) begin
        wait_d[j] = wait_q[j] + wait_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      data_q  <= '0;
      rr_q    <= '0;
      wait_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
      wait_q  <= wait_d;
    end
  end

  assign pop_o     = grant & {IN_PORTS{rst_ni}};
  assign valid_o   = valid_q;
  assign element_o = data_q;

endmodule

// File: tb/tb_fractal_sync_arbiter_hs.sv
// Directed bench: four arbiter configurations run in lockstep from one reset release.
module tb_fractal_sync_arbiter_hs;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [3:0][7:0] elem_in;
  logic [1:0][7:0] elem_c_in;

  // a: defaults (RR, 4 in, 2 out, MAX_WAIT 3)
  logic [3:0]      pop_a, empty_a;
  logic [1:0]      valid_a, ready_a;
  logic [1:0][7:0] elem_a;
  // b: fixed priority, 1 out, MAX_WAIT 2, input 2 idle
  logic [3:0]      pop_b, empty_b;
  logic [0:0]      valid_b, ready_b;
  logic [0:0][7:0] elem_b;
  // d: same config as b, input 2 drains and refills
  logic [3:0]      pop_d, empty_d;
  logic [0:0]      valid_d, ready_d;
  logic [0:0][7:0] elem_d;
  // c: 2 in, 4 out
  logic [1:0]      pop_c, empty_c;
  logic [3:0]      valid_c, ready_c;
  logic [3:0][7:0] elem_c;

  assign elem_in   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  assign elem_c_in = {8'hA1, 8'hA0};

  fractal_sync_arbiter_hs #(
    .IN_PORTS(4), .OUT_PORTS(2), .arbiter_t(logic [7:0]), .ARB_MODE(0), .MAX_WAIT(3)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .pop_o(pop_a), .empty_i(empty_a), .element_i(elem_in),
    .valid_o(valid_a), .ready_i(ready_a), .element_o(elem_a)
  );

  fractal_sync_arbiter_hs #(
    .IN_PORTS(4), .OUT_PORTS(1), .arbiter_t(logic [7:0]), .ARB_MODE(1), .MAX_WAIT(2)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .pop_o(pop_b), .empty_i(empty_b), .element_i(elem_in),
    .valid_o(valid_b), .ready_i(ready_b), .element_o(elem_b)
  );

  fractal_sync_arbiter_hs #(
    .IN_PORTS(4), .OUT_PORTS(1), .arbiter_t(logic [7:0]), .ARB_MODE(1), .MAX_WAIT(2)
  ) dut_d (
    .clk_i(clk), .rst_ni(rst_n), .pop_o(pop_d), .empty_i(empty_d), .element_i(elem_in),
    .valid_o(valid_d), .ready_i(ready_d), .element_o(elem_d)
  );

  fractal_sync_arbiter_hs #(
    .IN_PORTS(2), .OUT_PORTS(4), .arbiter_t(logic [7:0]), .ARB_MODE(0), .MAX_WAIT(3)
  ) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .pop_o(pop_c), .empty_i(empty_c), .element_i(elem_c_in),
    .valid_o(valid_c), .ready_i(ready_c), .element_o(elem_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    empty_a  = 4'b0000;
    ready_a  = 2'b11;
    empty_b  = 4'b0100;
    ready_b  = 1'b1;
    empty_d  = 4'b1010;
    ready_d  = 1'b1;
    empty_c  = 2'b00;
    ready_c  = 4'hF;

    // Held in reset with every input requesting
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pop_a", 32'(pop_a), 32'h0);
    chk("rst_valid_a", 32'(valid_a), 32'h0);
    chk("rst_elem_a", 32'(elem_a), 32'h0);
    chk("rst_pop_b", 32'(pop_b), 32'h0);

    // c1
    @(negedge clk); rst_n = 1'b1; #1;
    chk("c1_pop_a", 32'(pop_a), 32'h3);
    chk("c1_valid_a", 32'(valid_a), 32'h0);
    chk("c1_pop_b", 32'(pop_b), 32'h1);
    chk("c1_pop_d", 32'(pop_d), 32'h1);
    chk("c1_pop_c", 32'(pop_c), 32'h3);
    // c2
    @(negedge clk); #1;
    chk("c2_valid_a", 32'(valid_a), 32'h3);
    chk("c2_elem_a", 32'(elem_a), 32'hA1A0);
    chk("c2_pop_a", 32'(pop_a), 32'hC);
    chk("c2_pop_b", 32'(pop_b), 32'h1);
    chk("c2_elem_b", 32'(elem_b), 32'hA0);
    chk("c2_pop_d", 32'(pop_d), 32'h1);
    chk("c2_valid_c", 32'(valid_c), 32'h3);
    chk("c2_elem_c", 32'(elem_c), 32'h0000A1A0);
    // c3: input 2 of d drains while its counter sits at the threshold
    @(negedge clk); empty_d = 4'b1110; #1;
    chk("c3_pop_a", 32'(pop_a), 32'h3);
    chk("c3_elem_a", 32'(elem_a), 32'hA3A2);
    chk("c3_pop_b", 32'(pop_b), 32'h2);
    chk("c3_elem_b", 32'(elem_b), 32'hA0);
    chk("c3_pop_d", 32'(pop_d), 32'h1);
    // c4: d refills; a backpressures slot 0
    @(negedge clk); empty_d = 4'b1010; ready_a = 2'b10; #1;
    chk("c4_pop_a", 32'(pop_a), 32'h4);
    chk("c4_elem_a", 32'(elem_a), 32'hA1A0);
    chk("c4_pop_b", 32'(pop_b), 32'h8);
    chk("c4_elem_b", 32'(elem_b), 32'hA1);
    chk("c4_pop_d", 32'(pop_d), 32'h1);
    // c5
    @(negedge clk); #1;
    chk("c5_pop_a", 32'(pop_a), 32'h8);
    chk("c5_elem_a", 32'(elem_a), 32'hA2A0);
    chk("c5_pop_b", 32'(pop_b), 32'h1);
    chk("c5_elem_b", 32'(elem_b), 32'hA3);
    chk("c5_pop_d", 32'(pop_d), 32'h1);
    // c6
    @(negedge clk); #1;
    chk("c6_pop_a", 32'(pop_a), 32'h1);
    chk("c6_elem_a", 32'(elem_a), 32'hA3A0);
    chk("c6_pop_b", 32'(pop_b), 32'h2);
    chk("c6_pop_d", 32'(pop_d), 32'h4);
    // c7
    @(negedge clk); #1;
    chk("c7_pop_a", 32'(pop_a), 32'h2);
    chk("c7_elem_a", 32'(elem_a), 32'hA0A0);
    chk("c7_pop_b", 32'(pop_b), 32'h8);
    chk("c7_pop_d", 32'(pop_d), 32'h1);
    chk("c7_elem_d", 32'(elem_d), 32'hA2);
    // c8
    @(negedge clk); #1;
    chk("c8_pop_a", 32'(pop_a), 32'h4);
    chk("c8_elem_a", 32'(elem_a), 32'hA1A0);
    // c9: both slots stalled
    @(negedge clk); ready_a = 2'b00; #1;
    chk("c9_pop_a", 32'(pop_a), 32'h0);
    chk("c9_valid_a", 32'(valid_a), 32'h3);
    chk("c9_elem_a", 32'(elem_a), 32'hA2A0);
    // c10
    @(negedge clk); #1;
    chk("c10_pop_a", 32'(pop_a), 32'h0);
    chk("c10_elem_a", 32'(elem_a), 32'hA2A0);
    // Reset mid-transfer drops slot contents
    @(negedge clk); rst_n = 1'b0; #1;
    chk("mid_rst_valid_a", 32'(valid_a), 32'h0);
    chk("mid_rst_elem_a", 32'(elem_a), 32'h0);
    chk("mid_rst_pop_a", 32'(pop_a), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
